// File: rtl/mac_sched_pkg.sv
// ==========================================================================
// mac_sched_pkg : MAC instruction codes, scheduler state encoding, guard helpers. Rev 1.0
// ==========================================================================
`default_nettype none

package mac_sched_pkg;

   localparam logic [2:0] INS_CLR = 3'b000;
   localparam logic [2:0] INS_MUL = 3'b001;
   localparam logic [2:0] INS_MAC = 3'b010;
   localparam logic [2:0] INS_SAT = 3'b011;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FEED    = 3'd1,
      ST_SAT     = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   // Guard bits must be a plain sign extension of the 32-bit result.
   function automatic logic guard_ovf(input logic [31:0] r, input logic [7:0] p);
      return p != {8{r[31]}};
   endfunction

   function automatic logic [31:0] sat32(input logic [31:0] r, input logic [7:0] p);
      if (guard_ovf(r, p)) begin
         return p[7] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mac_sched_arb.sv
// ==========================================================================
// mac_rr_arb : two-requester round-robin arbiter, priority moves on job completion. Rev 1.0
// ==========================================================================
`default_nettype none

module mac_rr_arb (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   input  logic       owner_i,
   output logic [1:0] win_o
);

   // pri_q names the requester that wins a tie.
   logic pri_q;
   logic pri_d;

   always_comb begin
      pri_d = pri_q;
      if (upd_i) begin
         pri_d = ~owner_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pri_q <= 1'b0;
      end else begin
         pri_q <= pri_d;
      end
   end

   always_comb begin
      win_o = req_i;
      if (req_i == 2'b11) begin
         win_o = pri_q ? 2'b10 : 2'b01;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mac_sched.sv
// ==========================================================================
// mac_sched : schedules two requesters' dot-product jobs onto a shared MAC unit.
// Optional saturation step enabled by defining MAC_SCHED_SAT_EN. Rev 1.0
// ==========================================================================
`default_nettype none

module mac_sched
   import mac_sched_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req,
   input  logic [3:0]  len0,
   input  logic [3:0]  len1,
   input  logic [15:0] a0,
   input  logic [15:0] b0,
   input  logic [15:0] a1,
   input  logic [15:0] b1,
   input  logic [1:0]  valid,
   output logic [1:0]  ready,
   output logic [1:0]  gnt,
   output logic        done,
   output logic        done_id,
   output logic [31:0] done_result,
   output logic        done_ovf,
   output logic [2:0]  mac_instruction,
   output logic [15:0] mac_multiplier,
   output logic [15:0] mac_multiplicand,
   output logic        mac_stall,
   input  logic [31:0] mac_result,
   input  logic [7:0]  mac_protect
);

   state_t      state_q, state_d;
   logic [3:0]  len_q, len_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic [31:0] res_q, res_d;
   logic        ovf_q, ovf_d;

   logic [1:0]  w_win;
   logic [1:0]  w_owner_oh;
   logic [15:0] w_sel_a;
   logic [15:0] w_sel_b;
   logic        w_beat;
   logic        w_last_beat;

   mac_rr_arb u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req_i   (req),
      .upd_i   (done),
      .owner_i (owner_q),
      .win_o   (w_win)
   );

   assign w_owner_oh  = owner_q ? 2'b10 : 2'b01;
   assign w_sel_a     = owner_q ? a1 : a0;
   assign w_sel_b     = owner_q ? b1 : b0;
   assign w_beat      = reset_n && (state_q == ST_FEED) && (len_q != 4'd0) &&
                        (owner_q ? valid[1] : valid[0]);
   assign w_last_beat = w_beat && (cnt_q == len_q - 4'd1);

   assign done_id     = owner_q;
   assign done_result = res_q;
   assign done_ovf    = ovf_q;

   always_comb begin
      state_d          = state_q;
      len_d            = len_q;
      cnt_d            = cnt_q;
      owner_d          = owner_q;
      res_d            = res_q;
      ovf_d            = ovf_q;
      gnt              = 2'b00;
      ready            = 2'b00;
      done             = 1'b0;
      mac_instruction  = INS_MAC;
      mac_multiplier   = 16'd0;
      mac_multiplicand = 16'd0;
      mac_stall        = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (req != 2'b00) begin
               owner_d = w_win[1];
               len_d   = w_win[1] ? len1 : len0;
               cnt_d   = 4'd0;
               state_d = ST_FEED;
            end
         end

         ST_FEED: begin
            gnt = w_owner_oh;
            if (len_q == 4'd0) begin
               // Empty job: the MAC is never touched, result is a clean zero.
               mac_instruction = INS_CLR;
               res_d           = 32'd0;
               ovf_d           = 1'b0;
               state_d         = ST_DONE;
            end else begin
               ready = w_owner_oh;
               if (w_beat) begin
                  mac_instruction  = (cnt_q == 4'd0) ? INS_MUL : INS_MAC;
                  mac_multiplier   = w_sel_a;
                  mac_multiplicand = w_sel_b;
                  cnt_d            = cnt_q + 4'd1;
                  if (w_last_beat) begin
                     mac_stall = 1'b0;
`ifdef MAC_SCHED_SAT_EN
                     state_d   = ST_SAT;
`else
                     state_d   = ST_CAPTURE;
`endif
                  end
               end else if (cnt_q == 4'd0) begin
                  mac_instruction = INS_CLR;
               end
            end
         end

`ifdef MAC_SCHED_SAT_EN
         ST_SAT: begin
            gnt             = w_owner_oh;
            mac_instruction = INS_SAT;
            mac_stall       = 1'b0;
            state_d         = ST_CAPTURE;
         end
`endif

         ST_CAPTURE: begin
            gnt   = w_owner_oh;
            ovf_d = guard_ovf(mac_result, mac_protect);
`ifdef MAC_SCHED_SAT_EN
            res_d = sat32(mac_result, mac_protect);
`else
            res_d = mac_result;
`endif
            state_d = ST_DONE;
         end

         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Reset holds the MAC in clear and hides any half-finished job.
      if (!reset_n) begin
         gnt              = 2'b00;
         ready            = 2'b00;
         done             = 1'b0;
         mac_instruction  = INS_CLR;
         mac_multiplier   = 16'd0;
         mac_multiplicand = 16'd0;
         mac_stall        = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         len_q   <= 4'd0;
         cnt_q   <= 4'd0;
         owner_q <= 1'b0;
         res_q   <= 32'd0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         owner_q <= owner_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mac_sched.sv
// ==========================================================================
// tb_mac_sched : random + directed bench for mac_sched with a job-level reference model. Rev 1.0
// ==========================================================================
`default_nettype none

module tb_mac_sched;

`ifdef MAC_SCHED_SAT_EN
   localparam bit SAT_ON = 1'b1;
`else
   localparam bit SAT_ON = 1'b0;
`endif
   localparam int TAIL = SAT_ON ? 3 : 2;
   localparam logic signed [39:0] P_MAX = 40'sd2147483647;
   localparam logic signed [39:0] P_MIN = -40'sd2147483648;
   localparam longint S_MAX = 64'sd2147483647;
   localparam longint S_MIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  req = 2'b00;
   logic [1:0]  valid = 2'b00;
   logic [3:0]  len0 = 4'd0, len1 = 4'd0;
   logic [15:0] a0 = 16'd0, b0 = 16'd0, a1 = 16'd0, b1 = 16'd0;
   logic [1:0]  ready, gnt;
   logic        done, done_id, done_ovf, mac_stall;
   logic [31:0] done_result;
   logic [2:0]  mac_instruction;
   logic [15:0] mac_multiplier, mac_multiplicand;
   logic [31:0] mac_result;
   logic [7:0]  mac_protect;

   mac_sched dut (
      .clk(clk), .reset_n(reset_n), .req(req), .len0(len0), .len1(len1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .valid(valid), .ready(ready),
      .gnt(gnt), .done(done), .done_id(done_id), .done_result(done_result),
      .done_ovf(done_ovf), .mac_instruction(mac_instruction),
      .mac_multiplier(mac_multiplier), .mac_multiplicand(mac_multiplicand),
      .mac_stall(mac_stall), .mac_result(mac_result), .mac_protect(mac_protect)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // MAC unit: accumulator always advances, visible output register obeys stall.
   logic signed [39:0] m_acc = '0;
   logic signed [39:0] m_out = '0;
   assign mac_result  = m_out[31:0];
   assign mac_protect = m_out[39:32];

   function automatic logic signed [39:0] mac_next(input logic signed [39:0] acc,
         input logic [2:0] ins, input logic [15:0] x, input logic [15:0] y);
      logic signed [39:0] p;
      p = $signed(x) * $signed(y);
      case (ins)
         3'b000: return '0;
         3'b001: return p;
         3'b010: return acc + p;
         3'b011: begin
            if (acc > P_MAX) return P_MAX;
            if (acc < P_MIN) return P_MIN;
            return acc;
         end
         default: return acc;
      endcase
   endfunction

   always @(posedge clk) begin
      m_acc <= mac_next(m_acc, mac_instruction, mac_multiplier, mac_multiplicand);
      if (!mac_stall) m_out <= mac_next(m_acc, mac_instruction, mac_multiplier, mac_multiplicand);
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [1:0] oh(input bit o);
      return o ? 2'b10 : 2'b01;
   endfunction

   // {ovf, result} of a job whose exact dot product is s.
   function automatic logic [32:0] exp_res(input longint s);
      logic [39:0] w;
      if (SAT_ON) begin
         if (s > S_MAX) return {1'b0, 32'h7FFF_FFFF};
         if (s < S_MIN) return {1'b0, 32'h8000_0000};
         return {1'b0, s[31:0]};
      end
      w = s[39:0];
      return {w[39:32] != {8{w[31]}}, w[31:0]};
   endfunction

   // Job-level model: who owns the MAC, how many beats landed, cycles since the last one.
   bit     m_busy = 1'b0;
   bit     m_own  = 1'b0;
   bit     m_last = 1'b1;
   int     m_len = 0, m_beats = 0, m_tail = 0;
   longint m_sum = 0;

   always @(negedge clk) begin : p_compare
      logic [1:0]  e_gnt, e_rdy;
      logic        e_done, e_stall;
      logic [2:0]  e_ins;
      logic [15:0] e_ml, e_mc;
      logic [32:0] e_res;
      bit          len0_feed;
      int          done_tail;
      longint      pa, pb;

      done_tail = (m_len == 0) ? 1 : TAIL;
      e_gnt = 2'b00; e_rdy = 2'b00; e_done = 1'b0; e_stall = 1'b1;
      e_ins = 3'b010; e_ml = 16'd0; e_mc = 16'd0; len0_feed = 1'b0;

      if (!reset_n) begin
         e_ins = 3'b000;
      end else if (m_busy) begin
         if (m_tail == 0) begin
            e_gnt = oh(m_own);
            if (m_len == 0) begin
               len0_feed = 1'b1;
            end else begin
               e_rdy = e_gnt;
               if (valid[m_own]) begin
                  e_ins   = (m_beats == 0) ? 3'b001 : 3'b010;
                  e_ml    = m_own ? a1 : a0;
                  e_mc    = m_own ? b1 : b0;
                  e_stall = (m_beats != m_len - 1);
               end else begin
                  e_ins = (m_beats == 0) ? 3'b000 : 3'b010;
               end
            end
         end else if (m_tail < done_tail) begin
            e_gnt = oh(m_own);
            if (SAT_ON && m_tail == 1) begin
               e_ins   = 3'b011;
               e_stall = 1'b0;
            end
         end else begin
            e_done = 1'b1;
         end
      end

      chk("gnt", gnt, e_gnt);
      chk("ready", ready, e_rdy);
      chk("done", done, e_done);
      chk("mac_stall", mac_stall, e_stall);
      chk("mac_multiplier", mac_multiplier, e_ml);
      chk("mac_multiplicand", mac_multiplicand, e_mc);
      if (len0_feed)
         chk("len0_instruction", (mac_instruction == 3'b000 || mac_instruction == 3'b010), 1);
      else
         chk("mac_instruction", mac_instruction, e_ins);
      if (e_done) begin
         e_res = exp_res(m_sum);
         chk("done_id", done_id, m_own);
         chk("done_result", done_result, e_res[31:0]);
         chk("done_ovf", done_ovf, e_res[32]);
      end

      if (!reset_n) begin
         m_busy = 1'b0;
         m_last = 1'b1;
      end else if (!m_busy) begin
         if (req != 2'b00) begin
            m_own   = (req == 2'b11) ? ~m_last : req[1];
            m_len   = m_own ? int'(len1) : int'(len0);
            m_busy  = 1'b1;
            m_beats = 0;
            m_tail  = 0;
            m_sum   = 0;
         end
      end else if (m_tail == 0) begin
         if (m_len == 0) begin
            m_tail = 1;
         end else if (valid[m_own]) begin
            pa = $signed(m_own ? a1 : a0);
            pb = $signed(m_own ? b1 : b0);
            m_sum += pa * pb;
            m_beats++;
            if (m_beats == m_len) m_tail = 1;
         end
      end else if (m_tail == done_tail) begin
         m_busy = 1'b0;
         m_last = m_own;
      end else begin
         m_tail++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int lim, output int at, output logic [31:0] r,
                            output logic id, output logic ov);
      at = -1; r = '0; id = 1'b0; ov = 1'b0;
      for (int i = 0; i < lim && at < 0; i++) begin
         @(negedge clk);
         if (done) begin
            at = cyc; r = done_result; id = done_id; ov = done_ovf;
         end
      end
      if (at < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_done: no done pulse within %0d cycles (cycle %0d)", lim, cyc);
      end
   endtask

   task automatic job24(input string tag);
      int g, at; logic [31:0] r; logic id, ov;
      step(); req = 2'b01; len0 = 4'd3; g = cyc;
      step(); req = 2'b00; valid = 2'b01; a0 = 16'd2; b0 = 16'd3;
      step(); a0 = 16'd4; b0 = 16'd5;
      step(); a0 = 16'hFFFF; b0 = 16'd7;
      step(); valid = 2'b00;
      wait_done(12, at, r, id, ov);
      chk({tag, "_latency"}, at - g, SAT_ON ? 6 : 5);
      chk({tag, "_result"}, r, 32'd19);
      chk({tag, "_id"}, id, 1'b0);
      chk({tag, "_ovf"}, ov, 1'b0);
   endtask

   function automatic logic [3:0] pick_len();
      int k;
      k = $urandom % 8;
      if (k == 0) return 4'd0;
      if (k == 1) return 4'($urandom % 16);
      return 4'($urandom_range(1, 4));
   endfunction

   function automatic logic [15:0] pick_op();
      return ($urandom % 8 == 0) ? 16'h8000 : 16'($urandom);
   endfunction

   initial begin : p_stim
      int g, at, seen; logic [31:0] r; logic id, ov;

      repeat (3) step();
      @(negedge clk);
      chk("reset_instruction", mac_instruction, 3'b000);
      chk("reset_stall", mac_stall, 1'b1);
      chk("reset_gnt", gnt, 2'b00);
      step(); reset_n = 1'b1;
      @(negedge clk);
      chk("reset_done_result", done_result, 32'd0);
      chk("reset_done_id", done_id, 1'b0);
      chk("reset_done_ovf", done_ovf, 1'b0);

      // Both requesting from reset: 0 first, then strict alternation.
      step(); req = 2'b11; len0 = 4'd1; len1 = 4'd1; valid = 2'b11;
      a0 = 16'd1; b0 = 16'd1; a1 = 16'd2; b1 = 16'd2;
      for (int k = 0; k < 4; k++) begin
         wait_done(10, at, r, id, ov);
         chk($sformatf("rr_order_%0d", k), id, k % 2);
         chk($sformatf("rr_result_%0d", k), r, (k % 2) ? 32'd4 : 32'd1);
      end
      step(); req = 2'b00; valid = 2'b00;

      job24("back_to_back");

      // Two bubble cycles between the beats of a two-beat job.
      step(); req = 2'b01; len0 = 4'd2; g = cyc;
      step(); req = 2'b00; valid = 2'b01; a0 = 16'd2; b0 = 16'd2;
      for (int k = 0; k < 2; k++) begin
         step(); valid = 2'b00;
         @(negedge clk);
         chk($sformatf("bubble%0d_instruction", k), mac_instruction, 3'b010);
         chk($sformatf("bubble%0d_operands", k), {mac_multiplier, mac_multiplicand}, 32'd0);
         chk($sformatf("bubble%0d_stall", k), mac_stall, 1'b1);
      end
      step(); valid = 2'b01; a0 = 16'd3; b0 = 16'd3;
      step(); valid = 2'b00;
      wait_done(12, at, r, id, ov);
      chk("bubble_latency", at - g, 4 + TAIL);
      chk("bubble_result", r, 32'd13);

      // Zero-length job.
      step(); req = 2'b01; len0 = 4'd0; valid = 2'b01; a0 = 16'd5; b0 = 16'd5; g = cyc;
      step(); req = 2'b00;
      @(negedge clk);
      chk("len0_operands", {mac_multiplier, mac_multiplicand}, 32'd0);
      chk("len0_ready", ready, 2'b00);
      wait_done(6, at, r, id, ov);
      chk("len0_latency", at - g, 2);
      chk("len0_result", r, 32'd0);
      chk("len0_ovf", ov, 1'b0);
      valid = 2'b00;

      // Four (-32768)^2 beats: accumulator reaches 2^32.
      step(); req = 2'b01; len0 = 4'd4; valid = 2'b01; a0 = 16'h8000; b0 = 16'h8000; g = cyc;
      step(); req = 2'b00;
      repeat (3) step();
      step(); valid = 2'b00;
      wait_done(12, at, r, id, ov);
      chk("ovf_latency", at - g, 4 + TAIL);
      chk("ovf_result", r, SAT_ON ? 32'h7FFF_FFFF : 32'h0000_0000);
      chk("ovf_flag", ov, SAT_ON ? 1'b0 : 1'b1);

      // Reset during the second of four beats.
      step(); req = 2'b01; len0 = 4'd4; valid = 2'b01; a0 = 16'd1; b0 = 16'd1;
      step(); req = 2'b00;
      step(); reset_n = 1'b0;
      step(); reset_n = 1'b1; valid = 2'b00;
      @(negedge clk);
      chk("midreset_gnt", gnt, 2'b00);
      chk("midreset_done_result", done_result, 32'd0);
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("midreset_no_done", seen, 0);
      job24("after_reset");

      for (int i = 0; i < 4000; i++) begin
         step();
         reset_n = ($urandom % 400 != 0);
         for (int q = 0; q < 2; q++) begin
            if (!req[q]) req[q] = ($urandom % 3 == 0);
            else if (gnt[q] && $urandom % 3 == 0) req[q] = 1'b0;
            valid[q] = ($urandom % 4 != 0);
         end
         len0 = pick_len(); len1 = pick_len();
         a0 = pick_op(); b0 = pick_op(); a1 = pick_op(); b1 = pick_op();
      end
      step(); reset_n = 1'b1; req = 2'b00; valid = 2'b00;
      repeat (40) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
